// File: rtl/pipe_stall_ctrl.sv
// IF/ID pipeline register and stall/flush control for the load-use hazard path.
// Drives PC-write and ID/EX bubble, tracks stall episodes and keeps saturating statistics.
module pipe_stall_ctrl #(
    parameter int INST_W    = 19,
    parameter int PC_W      = 12,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              is_stall,
    input  logic              branch_taken,
    input  logic [INST_W-1:0] if_inst,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pc_write,
    output logic              id_ex_bubble,
    output logic [INST_W-1:0] id_inst,
    output logic [PC_W-1:0]   id_pc,
    output logic              id_valid,
    output logic              stall_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MAX_STALL_C = CNT_W'(MAX_STALL);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] run_len_r;
    logic [CNT_W-1:0] run_len_nxt_s;
    logic             flush_s;
    logic             stall_s;
    logic             err_set_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX_C) begin
            return v;
        end else begin
            return v + CNT_ONE_C;
        end
    endfunction

    // Effective hazard signals and the zero-latency pipeline controls
    always_comb begin
        flush_s      = branch_taken;
        // The stalling ID instruction is wrong-path on a flush, and a bubble never stalls.
        stall_s      = is_stall & id_valid & ~flush_s;
        pc_write     = rst_n & ~stall_s;
        id_ex_bubble = ~rst_n | stall_s | flush_s | ~id_valid;
    end

    // Stall-episode FSM: next state and run length
    always_comb begin
        state_nxt_s   = RUN;
        run_len_nxt_s = {CNT_W{1'b0}};
        case (state_r)
            RUN, FLUSH: begin
                if (flush_s) begin
                    state_nxt_s = FLUSH;
                end else if (stall_s) begin
                    state_nxt_s   = STALL;
                    run_len_nxt_s = CNT_ONE_C;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            STALL: begin
                if (flush_s) begin
                    state_nxt_s = FLUSH;
                end else if (stall_s) begin
                    state_nxt_s   = STALL;
                    run_len_nxt_s = sat_inc(run_len_r);
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s   = RUN;
                run_len_nxt_s = {CNT_W{1'b0}};
            end
        endcase
        err_set_s = stall_s & (run_len_nxt_s > MAX_STALL_C);
    end

    // FSM state and run-length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RUN;
            run_len_r <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            run_len_r <= run_len_nxt_s;
        end
    end

    // IF/ID register: flush clears to NOP, stall holds, otherwise load from IF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_inst  <= {INST_W{1'b0}};
            id_pc    <= {PC_W{1'b0}};
            id_valid <= 1'b0;
        end else if (flush_s) begin
            id_inst  <= {INST_W{1'b0}};
            id_pc    <= {PC_W{1'b0}};
            id_valid <= 1'b0;
        end else if (!stall_s) begin
            id_inst  <= if_inst;
            id_pc    <= if_pc;
            id_valid <= 1'b1;
        end
    end

    // Sticky runaway-stall flag and saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_err   <= 1'b0;
            stall_count <= {CNT_W{1'b0}};
            flush_count <= {CNT_W{1'b0}};
        end else begin
            if (err_set_s) begin
                stall_err <= 1'b1;
            end
            if (stall_s) begin
                stall_count <= sat_inc(stall_count);
            end
            if (flush_s) begin
                flush_count <= sat_inc(flush_count);
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector scoreboard bench for pipe_stall_ctrl; a CNT_W=4 instance shares
// the stimulus to exercise counter saturation.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst_n;
    logic        is_stall;
    logic        branch_taken;
    logic [18:0] if_inst;
    logic [11:0] if_pc;

    logic        pc_write, id_ex_bubble, id_valid, stall_err;
    logic [18:0] id_inst;
    logic [11:0] id_pc;
    logic [15:0] stall_count, flush_count;

    logic        s_pc_write, s_id_ex_bubble, s_id_valid, s_stall_err;
    logic [18:0] s_id_inst;
    logic [11:0] s_id_pc;
    logic [3:0]  s_stall_count, s_flush_count;

    typedef struct {
        logic        pw;
        logic        bub;
        logic [18:0] inst;
        logic [11:0] pc;
        logic        val;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  ssc;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    bit   drive_done;

    pipe_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .is_stall(is_stall), .branch_taken(branch_taken),
        .if_inst(if_inst), .if_pc(if_pc), .pc_write(pc_write), .id_ex_bubble(id_ex_bubble),
        .id_inst(id_inst), .id_pc(id_pc), .id_valid(id_valid), .stall_err(stall_err),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipe_stall_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .is_stall(is_stall), .branch_taken(branch_taken),
        .if_inst(if_inst), .if_pc(if_pc), .pc_write(s_pc_write), .id_ex_bubble(s_id_ex_bubble),
        .id_inst(s_id_inst), .id_pc(s_id_pc), .id_valid(s_id_valid), .stall_err(s_stall_err),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus plus the outputs expected at the following negedge
    task automatic vec(input logic rst, input logic st, input logic br,
                       input logic [18:0] inst, input logic [11:0] pc,
                       input logic e_pw, input logic e_bub, input logic [18:0] e_inst,
                       input logic [11:0] e_pc, input logic e_val, input logic e_err,
                       input logic [15:0] e_sc, input logic [15:0] e_fc, input logic [3:0] e_ssc);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n        = rst;
        is_stall     = st;
        branch_taken = br;
        if_inst      = inst;
        if_pc        = pc;
        e.pw = e_pw; e.bub = e_bub; e.inst = e_inst; e.pc = e_pc; e.val = e_val;
        e.err = e_err; e.sc = e_sc; e.fc = e_fc; e.ssc = e_ssc;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle and compare both instances
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_write",      32'(pc_write),       32'(e.pw));
                chk("id_ex_bubble",  32'(id_ex_bubble),   32'(e.bub));
                chk("id_inst",       32'(id_inst),        32'(e.inst));
                chk("id_pc",         32'(id_pc),          32'(e.pc));
                chk("id_valid",      32'(id_valid),       32'(e.val));
                chk("stall_err",     32'(stall_err),      32'(e.err));
                chk("stall_count",   32'(stall_count),    32'(e.sc));
                chk("flush_count",   32'(flush_count),    32'(e.fc));
                chk("s_pc_write",    32'(s_pc_write),     32'(e.pw));
                chk("s_bubble",      32'(s_id_ex_bubble), 32'(e.bub));
                chk("s_id_inst",     32'(s_id_inst),      32'(e.inst));
                chk("s_id_pc",       32'(s_id_pc),        32'(e.pc));
                chk("s_id_valid",    32'(s_id_valid),     32'(e.val));
                chk("s_stall_err",   32'(s_stall_err),    32'(e.err));
                chk("s_stall_count", 32'(s_stall_count),  32'(e.ssc));
                chk("s_flush_count", 32'(s_flush_count),  32'(e.fc[3:0]));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        total = 0; bad = 0; drive_done = 1'b0;
        rst_n = 1'b0; is_stall = 1'b0; branch_taken = 1'b0;
        if_inst = 19'h0; if_pc = 12'h0;
        //   rst  st    br    if_inst    if_pc    pw    bub   id_inst    id_pc    val   err   sc      fc      ssc
        vec(1'b0, 1'b0, 1'b0, 19'h00001, 12'h001, 1'b0, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
        vec(1'b1, 1'b0, 1'b0, 19'h12345, 12'h010, 1'b1, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
        vec(1'b1, 1'b0, 1'b0, 19'h0000A, 12'h014, 1'b1, 1'b0, 19'h12345, 12'h010, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
        // single-cycle stall
        vec(1'b1, 1'b1, 1'b0, 19'h0000B, 12'h018, 1'b0, 1'b1, 19'h0000A, 12'h014, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
        vec(1'b1, 1'b0, 1'b0, 19'h0000B, 12'h018, 1'b1, 1'b0, 19'h0000A, 12'h014, 1'b1, 1'b0, 16'd1, 16'd0, 4'd1);
        // four-cycle stall trips stall_err on the fourth edge
        vec(1'b1, 1'b1, 1'b0, 19'h0000C, 12'h01C, 1'b0, 1'b1, 19'h0000B, 12'h018, 1'b1, 1'b0, 16'd1, 16'd0, 4'd1);
        vec(1'b1, 1'b1, 1'b0, 19'h0000C, 12'h01C, 1'b0, 1'b1, 19'h0000B, 12'h018, 1'b1, 1'b0, 16'd2, 16'd0, 4'd2);
        vec(1'b1, 1'b1, 1'b0, 19'h0000C, 12'h01C, 1'b0, 1'b1, 19'h0000B, 12'h018, 1'b1, 1'b0, 16'd3, 16'd0, 4'd3);
        vec(1'b1, 1'b1, 1'b0, 19'h0000C, 12'h01C, 1'b0, 1'b1, 19'h0000B, 12'h018, 1'b1, 1'b0, 16'd4, 16'd0, 4'd4);
        vec(1'b1, 1'b0, 1'b0, 19'h0000C, 12'h01C, 1'b1, 1'b0, 19'h0000B, 12'h018, 1'b1, 1'b1, 16'd5, 16'd0, 4'd5);
        vec(1'b1, 1'b0, 1'b0, 19'h0000D, 12'h020, 1'b1, 1'b0, 19'h0000C, 12'h01C, 1'b1, 1'b1, 16'd5, 16'd0, 4'd5);
        // stall and flush together: flush wins
        vec(1'b1, 1'b1, 1'b1, 19'h0000E, 12'h024, 1'b1, 1'b1, 19'h0000D, 12'h020, 1'b1, 1'b1, 16'd5, 16'd0, 4'd5);
        vec(1'b1, 1'b0, 1'b0, 19'h0000E, 12'h024, 1'b1, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b1, 16'd5, 16'd1, 4'd5);
        // stall against an empty ID slot is ignored
        vec(1'b1, 1'b0, 1'b1, 19'h0000F, 12'h028, 1'b1, 1'b1, 19'h0000E, 12'h024, 1'b1, 1'b1, 16'd5, 16'd1, 4'd5);
        vec(1'b1, 1'b1, 1'b0, 19'h0000F, 12'h028, 1'b1, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b1, 16'd5, 16'd2, 4'd5);
        vec(1'b1, 1'b0, 1'b0, 19'h00010, 12'h02C, 1'b1, 1'b0, 19'h0000F, 12'h028, 1'b1, 1'b1, 16'd5, 16'd2, 4'd5);
        // long stall: the 4-bit counter saturates at 15
        for (int k = 0; k < 12; k++) begin
            vec(1'b1, 1'b1, 1'b0, 19'h00011, 12'h030, 1'b0, 1'b1, 19'h00010, 12'h02C, 1'b1, 1'b1,
                16'(5 + k), 16'd2, ((5 + k) > 15) ? 4'd15 : 4'(5 + k));
        end
        vec(1'b1, 1'b0, 1'b0, 19'h00011, 12'h030, 1'b1, 1'b0, 19'h00010, 12'h02C, 1'b1, 1'b1, 16'd17, 16'd2, 4'd15);
        // asynchronous reset mid-run, then reload after release
        vec(1'b0, 1'b0, 1'b0, 19'h00012, 12'h034, 1'b0, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
        vec(1'b1, 1'b0, 1'b0, 19'h12345, 12'h034, 1'b1, 1'b1, 19'h00000, 12'h000, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0);
        vec(1'b1, 1'b0, 1'b0, 19'h00001, 12'h038, 1'b1, 1'b0, 19'h12345, 12'h034, 1'b1, 1'b0, 16'd0, 16'd0, 4'd0);
        drive_done = 1'b1;
        for (int w = 0; w < 10; w++) begin
            if (exp_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
